// File: rtl/cas_adc_slicer_if.sv
// Signal bundle between the ADC front end, the cassette slicer and the machine core.
// The slave modport is the slicer; the master modport is whatever feeds samples and reads results.
interface cas_adc_slicer_if;
    logic [11:0] adc_data;
    logic        adc_sync;
    logic        clear;
    logic [11:0] sample;
    logic [11:0] avg;
    logic        cas_bit;
    logic        sample_valid;
    logic        bit_edge;
    logic [11:0] half_period;
    logic        carrier;

    modport master (
        output adc_data, adc_sync, clear,
        input  sample, avg, cas_bit, sample_valid, bit_edge, half_period, carrier
    );

    modport slave (
        input  adc_data, adc_sync, clear,
        output sample, avg, cas_bit, sample_valid, bit_edge, half_period, carrier
    );
endinterface

// File: rtl/cas_adc_slicer.sv
// Slices the line-in ADC stream into the cassette bit against a running window average,
// with hysteresis, and reports edge spacing and carrier presence.
module cas_adc_slicer #(
    parameter int WIN_LOG2   = 9,
    parameter int HYST       = 100,
    parameter int CARRIER_TO = 2400
) (
    input logic             clk,
    input logic             reset_n,
    cas_adc_slicer_if.slave bus
);
    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int TOT_W = 13 + WIN_LOG2;
    localparam int QW    = $clog2(CARRIER_TO + 1);
    localparam logic signed [13:0] HYST_S = 14'(HYST);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READ   = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] SLICE  = 2'd3;

    logic [1:0]          state;
    logic [2:0]          sync_q;
    logic                toggle;
    logic                pending;
    logic                go;
    logic [11:0]         hold;
    logic [11:0]         mem [0:DEPTH-1];
    logic [11:0]         rdata;
    logic [11:0]         old_eff;
    logic [WIN_LOG2-1:0] ptr;
    logic [WIN_LOG2:0]   fill;
    logic                full;
    logic [TOT_W-1:0]    total;
    logic [11:0]         avg_new;
    logic signed [13:0]  sample_s;
    logic signed [13:0]  avg_s;
    logic                next_bit;
    logic [11:0]         run;
    logic [11:0]         run_inc;
    logic [QW-1:0]       quiet;

    logic [11:0] sample_r;
    logic [11:0] avg_r;
    logic        cas_bit_r;
    logic        sample_valid_r;
    logic        bit_edge_r;
    logic [11:0] half_period_r;
    logic        carrier_r;

    assign bus.sample       = sample_r;
    assign bus.avg          = avg_r;
    assign bus.cas_bit      = cas_bit_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.bit_edge     = bit_edge_r;
    assign bus.half_period  = half_period_r;
    assign bus.carrier      = carrier_r;

    // Two flops for metastability, the third only to detect a change of level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], bus.adc_sync};
        end
    end

    assign toggle = sync_q[1] ^ sync_q[2];
    assign go     = toggle | pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold    <= 12'd0;
            pending <= 1'b0;
        end else begin
            if (toggle) begin
                hold <= bus.adc_data;
            end
            if (bus.clear || state == IDLE) begin
                pending <= 1'b0;
            end else if (toggle) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered-output window RAM; contents are never reset, fill masks stale entries.
    always_ff @(posedge clk) begin
        if (state == UPDATE && !bus.clear) begin
            mem[ptr] <= hold;
        end
        rdata <= mem[ptr];
    end

    assign full     = fill[WIN_LOG2];
    assign old_eff  = full ? rdata : 12'd0;
    assign run_inc  = (run == 12'hFFF) ? 12'hFFF : run + 12'd1;
    assign avg_new  = total[WIN_LOG2+11:WIN_LOG2];
    assign sample_s = signed'({2'b00, hold});
    assign avg_s    = signed'({2'b00, avg_new});

    // Signed compare so the band stays correct when the average sits near either rail.
    always_comb begin
        next_bit = cas_bit_r;
        if (full) begin
            if (sample_s < avg_s - HYST_S) begin
                next_bit = 1'b1;
            end else if (sample_s > avg_s + HYST_S) begin
                next_bit = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            fill           <= '0;
            total          <= '0;
            run            <= 12'd0;
            quiet          <= '0;
            sample_r       <= 12'd0;
            avg_r          <= 12'd0;
            cas_bit_r      <= 1'b0;
            sample_valid_r <= 1'b0;
            bit_edge_r     <= 1'b0;
            half_period_r  <= 12'd0;
            carrier_r      <= 1'b0;
        end else begin
            sample_valid_r <= 1'b0;
            bit_edge_r     <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                ptr       <= '0;
                fill      <= '0;
                total     <= '0;
                run       <= 12'd0;
                quiet     <= '0;
                cas_bit_r <= 1'b0;
                carrier_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            state <= READ;
                        end
                    end
                    READ: begin
                        state <= UPDATE;
                    end
                    UPDATE: begin
                        total <= total - TOT_W'(old_eff) + TOT_W'(hold);
                        ptr   <= ptr + 1'b1;
                        if (!full) begin
                            fill <= fill + 1'b1;
                        end
                        state <= SLICE;
                    end
                    default: begin
                        sample_r       <= hold;
                        avg_r          <= avg_new;
                        cas_bit_r      <= next_bit;
                        sample_valid_r <= 1'b1;
                        if (next_bit != cas_bit_r) begin
                            bit_edge_r    <= 1'b1;
                            half_period_r <= run_inc;
                            run           <= 12'd0;
                            quiet         <= '0;
                            carrier_r     <= 1'b1;
                        end else begin
                            run <= run_inc;
                            if (quiet != QW'(CARRIER_TO)) begin
                                quiet <= quiet + QW'(1);
                                if (quiet == QW'(CARRIER_TO - 1)) begin
                                    carrier_r <= 1'b0;
                                end
                            end
                        end
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cas_adc_slicer.sv
// Bench for cas_adc_slicer: spec-derived directed tables plus random samples checked
// against a window-sum reference model.
module tb_cas_adc_slicer;
    localparam int WIN  = 512;
    localparam int HYST = 100;
    localparam int CTO  = 2400;

    typedef struct packed {
        logic [11:0] sample;
        logic [11:0] avg;
        logic        cas;
        logic        edg;
        logic [11:0] half;
        logic        car;
    } obs_t;

    typedef struct {
        int value;
        int exp_cas;
        int exp_edge;
        int exp_avg;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cas_adc_slicer_if bus ();

    cas_adc_slicer #(.WIN_LOG2(9), .HYST(HYST), .CARRIER_TO(CTO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int passed = 0;
    int checks = 0;

    int win[$];
    int m_sample, m_avg, m_cas, m_edge, m_half, m_run, m_quiet, m_carrier;

    function automatic obs_t observe();
        obs_t o;
        o.sample = bus.sample;
        o.avg    = bus.avg;
        o.cas    = bus.cas_bit;
        o.edg    = bus.bit_edge;
        o.half   = bus.half_period;
        o.car    = bus.carrier;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.sample = 12'(m_sample);
        o.avg    = 12'(m_avg);
        o.cas    = m_cas[0];
        o.edg    = m_edge[0];
        o.half   = 12'(m_half);
        o.car    = m_carrier[0];
        return o;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_output(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got sample=%0d avg=%0d cas=%0d edge=%0d half=%0d car=%0d, expected sample=%0d avg=%0d cas=%0d edge=%0d half=%0d car=%0d",
                      name, act.sample, act.avg, act.cas, act.edg, act.half, act.car,
                      exp.sample, exp.avg, exp.cas, exp.edg, exp.half, exp.car);
    endtask

    task automatic model_clear();
        win.delete();
        m_cas = 0; m_edge = 0; m_run = 0; m_quiet = 0; m_carrier = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_sample = 0; m_avg = 0; m_half = 0;
    endtask

    // Average is the plain sum of the last (up to) 512 samples divided by 512.
    task automatic model_step(input int v);
        int sum;
        int nb;
        int drop;
        win.push_back(v);
        if (win.size() > WIN) drop = win.pop_front();
        sum = 0;
        foreach (win[i]) sum += win[i];
        m_avg = sum / WIN;
        nb = m_cas;
        if (win.size() == WIN) begin
            if (v < m_avg - HYST) nb = 1;
            else if (v > m_avg + HYST) nb = 0;
        end
        m_edge = (nb != m_cas) ? 1 : 0;
        m_cas = nb;
        m_sample = v;
        if (m_edge == 1) begin
            m_half = (m_run + 1 > 4095) ? 4095 : m_run + 1;
            m_run = 0;
            m_quiet = 0;
            m_carrier = 1;
        end else begin
            if (m_run < 4095) m_run++;
            if (m_quiet < CTO) begin
                m_quiet++;
                if (m_quiet == CTO) m_carrier = 0;
            end
        end
    endtask

    task automatic apply_stimulus(input int v, output obs_t got);
        int cyc;
        bus.adc_data = 12'(v);
        bus.adc_sync = ~bus.adc_sync;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.sample_valid && cyc < 16);
        got = observe();
        check_int("latency", cyc, 6);
        model_step(v);
        check_output("sample", got, model_obs());
        @(negedge clk);
        check_int("pulse_width", int'({bus.sample_valid, bus.bit_edge}), 0);
    endtask

    vec_t vecs[4];
    obs_t got;
    obs_t zero_obs;
    int edges;
    int valids;

    initial begin
        vecs[0] = '{value: 1947, exp_cas: 0, exp_edge: 0, exp_avg: 2047};
        vecs[1] = '{value: 1940, exp_cas: 1, exp_edge: 1, exp_avg: 2047};
        vecs[2] = '{value: 2140, exp_cas: 1, exp_edge: 0, exp_avg: 2047};
        vecs[3] = '{value: 2150, exp_cas: 0, exp_edge: 1, exp_avg: 2047};
        zero_obs = '0;

        bus.adc_data = 12'd0;
        bus.adc_sync = 1'b0;
        bus.clear    = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_state", observe(), zero_obs);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Window fill at mid-scale: no slicing until 512 samples are in.
        for (int i = 1; i <= 511; i++) apply_stimulus(2048, got);
        check_int("fill_avg_511", int'(got.avg), 2044);
        check_int("fill_cas_511", int'(got.cas), 0);
        apply_stimulus(2048, got);
        check_int("fill_avg_512", int'(got.avg), 2048);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].value, got);
            check_int("hyst_cas", int'(got.cas), vecs[i].exp_cas);
            check_int("hyst_edge", int'(got.edg), vecs[i].exp_edge);
            check_int("hyst_avg", int'(got.avg), vecs[i].exp_avg);
        end

        // Square wave +/-400, 10 samples per half, ending on an edge.
        edges = 0;
        for (int i = 0; i < 121; i++) begin
            apply_stimulus((((i / 10) % 2) == 1) ? 1648 : 2448, got);
            if (got.edg) begin
                edges++;
                if (i >= 20) check_int("sq_half", int'(got.half), 10);
                check_int("sq_carrier", int'(got.car), 1);
            end
            if (i % 20 == 19) check_int("sq_avg_band", int'(got.avg >= 12'd2047 && got.avg <= 12'd2049), 1);
        end
        check_int("sq_edges", edges, 12);

        // Quiet line: carrier drops on the 2400th edge-free sample, then run saturates.
        for (int k = 1; k <= 4200; k++) begin
            apply_stimulus(2048, got);
            if (k == 2399) check_int("carrier_2399", int'(got.car), 1);
            if (k == 2400) begin
                check_int("carrier_2400", int'(got.car), 0);
                check_int("half_kept", int'(got.half), 10);
            end
        end
        apply_stimulus(1648, got);
        check_int("gap_edge", int'(got.edg), 1);
        check_int("gap_half_sat", int'(got.half), 4095);
        check_int("gap_carrier", int'(got.car), 1);

        for (int i = 0; i < 1200; i++) apply_stimulus(int'($urandom_range(0, 4095)), got);

        // Clear lands while the sequence is in READ; the sample must be abandoned.
        bus.adc_data = 12'd777;
        bus.adc_sync = ~bus.adc_sync;
        repeat (3) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        valids = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.sample_valid) valids++;
            @(negedge clk);
        end
        check_int("clear_no_valid", valids, 0);
        model_clear();
        check_output("clear_state", observe(), model_obs());

        // Near-zero average after the clear: no wraparound false edges.
        edges = 0;
        for (int i = 0; i < 520; i++) begin
            apply_stimulus(($urandom_range(0, 1) == 1) ? 50 : 0, got);
            if (got.edg) edges++;
        end
        check_int("low_no_edges", edges, 0);
        check_int("low_cas", int'(got.cas), 0);

        // Async reset while in UPDATE.
        bus.adc_data = 12'd3333;
        bus.adc_sync = ~bus.adc_sync;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        bus.adc_sync = 1'b0;
        #1;
        check_output("reset_in_update", observe(), zero_obs);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 20; i++) apply_stimulus(3000, got);
        check_int("post_reset_avg", int'(got.avg), 117);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
